// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter: synchronises N_REQ async pulse lines, latches their rising edges as pending
// events and serves them round-robin on a valid/ready port. Define PULSE_ARB_COUNT_EN for per-line counters.
module pulse_event_arbiter_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse,
  input  logic             accept,
  input  logic             clear_ovf,
  output logic             pending,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);
  logic [SYNC_STAGES-1:0] sff;
  logic                   sync_d;
  logic                   rise;

  assign rise = sff[SYNC_STAGES-1] & ~sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sff      <= '0;
      sync_d   <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sff    <= {sff[SYNC_STAGES-2:0], pulse};
      sync_d <= sff[SYNC_STAGES-1];
      // an edge coinciding with acceptance is a fresh event, not an overflow
      if (accept)    pending <= rise;
      else if (rise) pending <= 1'b1;
      if (clear_ovf)                         overflow <= 1'b0;
      else if (rise && pending && !accept)   overflow <= 1'b1;
    end
  end

`ifdef PULSE_ARB_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          count <= '0;
    else if (clear_ovf)                 count <= '0;
    else if (accept && (count != '1))   count <= count + 1'b1;
  end
`else
  assign count = '0;
`endif
endmodule

module pulse_event_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         pulse,
  output logic                     evt_valid,
  output logic [$clog2(N_REQ)-1:0] evt_id,
  input  logic                     evt_ready,
  output logic [N_REQ-1:0]         overflow,
  input  logic                     clear_ovf,
  output logic [N_REQ*CNT_W-1:0]   evt_count
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_nx;

  logic [N_REQ-1:0]            pending;
  logic [N_REQ-1:0]            accept;
  logic [N_REQ-1:0][CNT_W-1:0] cnt;
  logic [IDW-1:0]              rr_ptr, rr_nx, id_nx, sel;
  logic                        found;

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_lane
      pulse_event_arbiter_lane #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) u_lane (
        .clk      (clk),
        .reset    (reset),
        .pulse    (pulse[g]),
        .accept   (accept[g]),
        .clear_ovf(clear_ovf),
        .pending  (pending[g]),
        .overflow (overflow[g]),
        .count    (cnt[g])
      );
    end
  endgenerate

  assign evt_count = cnt;
  assign evt_valid = (state == OFFER);

  // first pending line at or after rr_ptr, wrapping
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    sel   = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && pending[j]) begin
        found = 1'b1;
        sel   = IDW'(j);
      end
    end
  end

  always_comb begin
    state_nx = state;
    id_nx    = evt_id;
    rr_nx    = rr_ptr;
    accept   = '0;
    case (state)
      IDLE: if (found) begin
        state_nx = OFFER;
        id_nx    = sel;
      end
      OFFER: if (evt_ready) begin
        accept[evt_id] = 1'b1;
        rr_nx          = (evt_id == IDW'(N_REQ-1)) ? '0 : evt_id + 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      evt_id <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      evt_id <= id_nx;
      rr_ptr <= rr_nx;
    end
  end
endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Scoreboard bench for pulse_event_arbiter: expected ids queued at stimulus, popped on each transfer.
module tb_pulse_event_arbiter;
  localparam int N_REQ = 4, SYNC_STAGES = 2, CNT_W = 8;

  logic                   clk = 1'b1;
  logic                   rst = 1'b0;
  logic [N_REQ-1:0]       pulse_drv = '0, pulse_rep = '0;
  logic [N_REQ-1:0]       pulse;
  logic                   evt_valid, evt_ready = 1'b0, clear_ovf = 1'b0;
  logic [1:0]             evt_id;
  logic [N_REQ-1:0]       overflow;
  logic [N_REQ*CNT_W-1:0] evt_count;

  int vectors = 0, miscompares = 0;
  int exp_q[$];
  bit prev_xfer = 0;
  int rep_limit = 0, rep_done = 0;
  int rep_cnt[N_REQ];

  assign pulse = pulse_drv | pulse_rep;
  always #5 clk = ~clk;

  pulse_event_arbiter #(.N_REQ(N_REQ), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst), .pulse(pulse), .evt_valid(evt_valid), .evt_id(evt_id),
    .evt_ready(evt_ready), .overflow(overflow), .clear_ovf(clear_ovf), .evt_count(evt_count)
  );

  // transfer monitor: every valid&&ready must match the next queued id, never back to back
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL xfer: unexpected transfer id=%0d, none expected", evt_id);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (evt_id !== 2'(e)) begin
          miscompares++;
          $display("FAIL xfer_id: got %0d expected %0d", evt_id, e);
        end
      end
      if (prev_xfer) begin
        miscompares++;
        $display("FAIL gap: transfers in consecutive cycles, got 0 idle cycles expected >=1");
      end
      prev_xfer = 1;
    end else prev_xfer = 0;
  end

  // re-pulses the line just served, for the fairness scenario
  always @(negedge clk) begin
    for (int i = 0; i < N_REQ; i++) if (rep_cnt[i] > 0) rep_cnt[i]--;
    if (!rst && evt_valid && evt_ready && rep_done < rep_limit) begin
      rep_cnt[evt_id] = 3;
      rep_done++;
    end
    for (int i = 0; i < N_REQ; i++) pulse_rep[i] = (rep_cnt[i] != 0);
  end

  task tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task pulse_lines(input logic [N_REQ-1:0] m, input int hi);
    pulse_drv = pulse_drv | m;
    tick(hi);
    pulse_drv = pulse_drv & ~m;
  endtask

  task do_reset;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    tick(1);
  endtask

  task test_reset;
    #1 rst = 1'b1;
    #7;
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", evt_valid); end
    vectors++; if (evt_id !== 2'd0) begin miscompares++; $display("FAIL rst_id: got %0d expected 0", evt_id); end
    vectors++; if (overflow !== 4'b0) begin miscompares++; $display("FAIL rst_ovf: got %b expected 0000", overflow); end
    vectors++; if (evt_count !== '0) begin miscompares++; $display("FAIL rst_cnt: got %h expected 0", evt_count); end
    #4 rst = 1'b0;
    #13;
  endtask

  task test_single;
    int n;
    n = 0;
    evt_ready = 1'b1;
    exp_q.push_back(1);
    pulse_drv[1] = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!evt_valid && n < 12);
    vectors++; if (n != SYNC_STAGES + 2) begin miscompares++; $display("FAIL latency: got %0d clk expected %0d", n, SYNC_STAGES + 2); end
    vectors++; if (evt_id !== 2'd1) begin miscompares++; $display("FAIL single_id: got %0d expected 1", evt_id); end
    tick(1);
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL valid_width: got %b expected 0", evt_valid); end
    #14 pulse_drv[1] = 1'b0;
    tick(8);
    vectors++; if (overflow !== 4'b0) begin miscompares++; $display("FAIL single_ovf: got %b expected 0000", overflow); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task test_simultaneous;
    do_reset();
    evt_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
    pulse_lines(4'b1101, 3);
    tick(30);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL simul_drain: got %0d left expected 0", exp_q.size()); end
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL simul_idle: got %b expected 0", evt_valid); end
    vectors++; if (overflow !== 4'b0) begin miscompares++; $display("FAIL simul_ovf: got %b expected 0000", overflow); end
  endtask

  task test_overflow;
    evt_ready = 1'b0;
    pulse_lines(4'b0100, 3);
    tick(3);
    pulse_lines(4'b0100, 3);
    tick(6);
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid: got %b expected 1", evt_valid); end
    vectors++; if (evt_id !== 2'd2) begin miscompares++; $display("FAIL ovf_id: got %0d expected 2", evt_id); end
    vectors++; if (overflow !== 4'b0100) begin miscompares++; $display("FAIL ovf_flag: got %b expected 0100", overflow); end
    exp_q.push_back(2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    evt_ready = 1'b1;
    tick(10);
    vectors++; if (overflow !== 4'b0) begin miscompares++; $display("FAIL ovf_clear: got %b expected 0000", overflow); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL ovf_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task test_fairness;
    int n;
    do_reset();
    evt_ready = 1'b1;
    for (int k = 0; k < 12; k++) exp_q.push_back(k % 4);
    rep_done  = 0;
    rep_limit = 8;
    pulse_lines(4'b1111, 3);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(1); n++; end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL fair_timeout: got %0d left expected 0", exp_q.size()); end
    tick(10);
    rep_limit = 0;
    vectors++; if (overflow !== 4'b0) begin miscompares++; $display("FAIL fair_ovf: got %b expected 0000", overflow); end
  endtask

  task test_reset_mid_offer;
    int n;
    do_reset();
    evt_ready = 1'b0;
    pulse_lines(4'b0010, 3);
    n = 0;
    while (!evt_valid && n < 12) begin tick(1); n++; end
    vectors++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin miscompares++; $display("FAIL mid_offer: got valid=%b id=%0d expected valid=1 id=1", evt_valid, evt_id); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_async: got %b expected 0", evt_valid); end
    @(posedge clk); #2 rst = 1'b0;
    evt_ready = 1'b1;
    tick(10);
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_after: got %b expected 0", evt_valid); end
  endtask

  task test_counters;
    logic [N_REQ*CNT_W-1:0] exp_cnt;
`ifdef PULSE_ARB_COUNT_EN
    exp_cnt = 32'hFF00_0000;
`else
    exp_cnt = '0;
`endif
    do_reset();
    evt_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      exp_q.push_back(3);
      pulse_lines(4'b1000, 3);
      tick(3);
    end
    tick(10);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL cnt_drain: got %0d left expected 0", exp_q.size()); end
    vectors++; if (evt_count !== exp_cnt) begin miscompares++; $display("FAIL cnt_sat: got %h expected %h", evt_count, exp_cnt); end
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    tick(1);
    vectors++; if (evt_count !== '0) begin miscompares++; $display("FAIL cnt_clear: got %h expected 0", evt_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_fairness();
    test_reset_mid_offer();
    test_counters();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
